imem_fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the asynchronous-read instruction memory (imemory).

---
 rtl/imem_fetch_ctrl_pkg.sv | 6 +
 rtl/imem_fetch_ctrl_fifo.sv | 35 +++
 rtl/imem_fetch_ctrl.sv | 59 +++++
 tb/tb_imem_fetch_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// imem_fetch_ctrl_pkg: shared constants and FSM encoding for the instruction-fetch sequencer.
package imem_fetch_ctrl_pkg;
    localparam int WORD_BYTES = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;
endpackage

// File: rtl/imem_fetch_ctrl_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with push/pop/flush; flush beats push and pop.
module fetch_fifo #(
    parameter int W = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q;
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= push ? wr_q + 1'b1 : wr_q;
            rd_q    <= pop ? rd_q + 1'b1 : rd_q;
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= din;
    end
    assign dout  = mem_q[rd_q];
    assign count = count_q;
endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fetch PC sequencer feeding imemory reads into a prefetch FIFO for decode.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] imem_adr,
    input  logic [WIDTH-1:0] imem_data,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [WIDTH-1:0] inst_data,
    output logic [WIDTH-1:0] inst_pc,
    output logic             busy,
    output logic [CW-1:0]    fifo_count
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d, head_pc, head_data;
    logic             push, pop;
    assign inst_valid = fifo_count != '0;
    assign pop        = inst_valid && inst_ready;
    assign push       = (state_q == ST_RUN) && !redirect_valid && (fifo_count < CW'(DEPTH) || pop);
    assign busy       = state_q == ST_RUN;
    assign imem_adr   = pc_q;
    assign inst_data  = inst_valid ? head_data : '0;
    assign inst_pc    = inst_valid ? head_pc : '0;
    fetch_fifo #(.W(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({pc_q, imem_data}),
        .dout  ({head_pc, head_data}),
        .count (fifo_count)
    );
    // stop outranks start; redirect target is forced word-aligned
    always_comb begin
        state_d = stop ? ST_IDLE : start ? ST_RUN : state_q;
        pc_d    = redirect_valid ? (redirect_pc & ~WIDTH'(3)) : push ? pc_q + WIDTH'(WORD_BYTES) : pc_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: randomized + directed bench with a queue-based reference model and scoreboard.
module tb_imem_fetch_ctrl;
    localparam int D = 4;
    logic        clk = 0, reset = 1, start = 0, stop = 0, redirect_valid = 0, inst_ready = 0;
    logic [31:0] redirect_pc = 0, imem_adr, imem_data, inst_data, inst_pc;
    logic        inst_valid, busy;
    logic [2:0]  fifo_count;
    int          n_chk = 0, n_fail = 0;
    bit          mon_en = 0;
    bit          m_run = 0;
    logic [31:0] m_pc = 0;
    int          m_count = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a >> 2;
    endfunction
    assign imem_data = rom(imem_adr);

    imem_fetch_ctrl #(.WIDTH(32), .DEPTH(D), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_adr(imem_adr), .imem_data(imem_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc),
        .busy(busy), .fifo_count(fifo_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: fetch stream as a queue of {pc, word} the decode side should see.
    always @(posedge clk) begin
        bit pop, push;
        if (reset) begin
            m_run = 0; m_pc = 0; m_count = 0; exp_q.delete();
        end else begin
            pop  = m_count > 0 && inst_ready;
            push = m_run && !redirect_valid && (m_count < D || pop);
            if (redirect_valid) begin
                exp_q.delete(); m_count = 0; m_pc = redirect_pc & ~32'h3;
            end else begin
                if (push) begin
                    exp_q.push_back({m_pc, rom(m_pc)});
                    m_pc += 4;
                end
                m_count += int'(push) - int'(pop);
            end
            if (stop) m_run = 0;
            else if (start) m_run = 1;
        end
    end

    // Monitor: checks status every cycle and consumes the scoreboard on each handshake.
    always @(negedge clk) begin
        logic [63:0] e;
        if (mon_en) begin
            chk("inst_valid", 32'(inst_valid), 32'(m_count != 0));
            chk("fifo_count", 32'(fifo_count), 32'(m_count));
            chk("imem_adr", imem_adr, m_pc);
            chk("busy", 32'(busy), 32'(m_run));
            if (!inst_valid) begin
                chk("inst_data_mask", inst_data, 32'h0);
                chk("inst_pc_mask", inst_pc, 32'h0);
            end else if (inst_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_pop: got pc %h expected no entry", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("head_pc", inst_pc, e[63:32]);
                    chk("head_data", inst_data, e[31:0]);
                end
            end
        end
    end

    initial begin
        step(); step();
        reset = 0;
        mon_en = 1;
        chk("rst_adr", imem_adr, 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_count", 32'(fifo_count), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        // streaming from reset
        inst_ready = 1; start = 1; step(); start = 0;
        chk("t1_not_yet", 32'(inst_valid), 32'h0);
        step();
        chk("t1_first_pc", inst_pc, 32'h0);
        chk("t1_first_data", inst_data, 32'h0);
        step();
        chk("t1_second_pc", inst_pc, 32'h4);
        repeat (6) step();
        // fill with decode stalled
        redirect_valid = 1; redirect_pc = 0; inst_ready = 0; step(); redirect_valid = 0;
        repeat (6) step();
        chk("t2_full", 32'(fifo_count), 32'd4);
        chk("t2_adr_hold", imem_adr, 32'h10);
        inst_ready = 1; step(); inst_ready = 0;
        chk("t3_count_stays", 32'(fifo_count), 32'd4);
        chk("t3_adr", imem_adr, 32'h14);
        chk("t3_head", inst_pc, 32'h4);
        inst_ready = 1; repeat (4) step();
        // redirect while entries queued and a pop in flight
        redirect_valid = 1; redirect_pc = 0; inst_ready = 0; step(); redirect_valid = 0;
        repeat (3) step();
        chk("t4_queued", 32'(fifo_count), 32'd3);
        redirect_valid = 1; redirect_pc = 32'h103; inst_ready = 1; step(); redirect_valid = 0;
        chk("t4_flush_valid", 32'(inst_valid), 32'h0);
        chk("t4_flush_count", 32'(fifo_count), 32'h0);
        chk("t4_target_adr", imem_adr, 32'h100);
        step();
        chk("t4_target_pc", inst_pc, 32'h100);
        // stop after two pushes, drain, resume
        redirect_valid = 1; redirect_pc = 0; inst_ready = 0; step(); redirect_valid = 0;
        step();
        stop = 1; step(); stop = 0;
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_count", 32'(fifo_count), 32'd2);
        step();
        chk("t5_no_push", 32'(fifo_count), 32'd2);
        inst_ready = 1; step(); step();
        chk("t5_drained", 32'(fifo_count), 32'h0);
        start = 1; step(); start = 0; step();
        chk("t5_resume_pc", inst_pc, 32'h8);
        // reset over full FIFO, redirect and start
        inst_ready = 0; repeat (5) step();
        chk("t6_full", 32'(fifo_count), 32'd4);
        reset = 1; redirect_valid = 1; redirect_pc = 32'h40; start = 1; step();
        reset = 0; redirect_valid = 0; start = 0;
        chk("t6_adr", imem_adr, 32'h0);
        chk("t6_valid", 32'(inst_valid), 32'h0);
        chk("t6_data", inst_data, 32'h0);
        chk("t6_pc", inst_pc, 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_count", 32'(fifo_count), 32'h0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(299) == 0);
            start          = ($urandom_range(7) == 0);
            stop           = ($urandom_range(29) == 0);
            redirect_valid = ($urandom_range(14) == 0);
            redirect_pc    = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : $urandom;
            inst_ready     = ($urandom_range(9) < 7);
            step();
        end
        reset = 0; start = 0; stop = 0; redirect_valid = 0; inst_ready = 1;
        repeat (10) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
